// File: rtl/stream_mux4x.sv
// ---------------------------------------------------------------------------
// stream_mux4x
//   Registered N-to-1 stream multiplexer with valid/ready handshakes on every
//   channel. In fixed mode (i_mode=0) i_sel picks the source channel. In
//   round-robin mode (i_mode=1) the block grants the first valid channel
//   above the last round-robin winner, wrapping to 0.
//
//   A single output register holds one word. It reloads whenever it is empty
//   or being drained in the same cycle, so a continuous stream runs at one
//   word per clock.
//
// Parameters
//   WIDTH     data bits per channel (>=1)
//   CHANNELS  number of input channels (2..16)
//   SEL_W     channel-index width, equal to clog2(CHANNELS)
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_mode       0 = fixed select, 1 = round-robin
//   i_sel        source channel in fixed mode
//   i_in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   i_in_valid   per-channel valid
//   o_in_ready   per-channel ready, at most one bit high
//   o_out_data   registered output word
//   o_out_valid  output register holds a word
//   i_out_ready  downstream accepts the word
//   o_out_chan   channel that supplied o_out_data
// ---------------------------------------------------------------------------
module stream_mux4x #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [CHANNELS*WIDTH-1:0] i_in_data,
  input  logic [CHANNELS-1:0]       i_in_valid,
  output logic [CHANNELS-1:0]       o_in_ready,
  output logic [WIDTH-1:0]          o_out_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [SEL_W-1:0]          o_out_chan
);

  localparam int NSEL = 2 ** SEL_W;

  // Output register and round-robin pointer
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan;
  logic             r_valid;
  logic [SEL_W-1:0] r_last;

  // Combinational selection
  logic             w_load;
  logic [NSEL-1:0]  w_valid_pad;
  logic [SEL_W:0]   w_idx;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_chan;
  logic             w_fix_ok;
  logic             w_cand_ok;
  logic [SEL_W-1:0] w_cand;
  logic             w_cand_valid;
  logic [WIDTH-1:0] w_cand_data;
  logic             w_xfer;

  // The register can take a new word when empty or when its word leaves now.
  assign w_load = !r_valid || i_out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    // Pad valid to the full index range so a select beyond CHANNELS reads 0.
    w_valid_pad                 = '0;
    w_valid_pad[CHANNELS-1:0]   = i_in_valid;

    // Round-robin search from r_last+1 upward, wrapping at CHANNELS.
    w_rr_found = 1'b0;
    w_rr_chan  = '0;
    w_idx      = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_idx = {1'b0, r_last} + (SEL_W+1)'(k);
      if (w_idx >= (SEL_W+1)'(CHANNELS)) begin
        w_idx = w_idx - (SEL_W+1)'(CHANNELS);
      end
      if (!w_rr_found && w_valid_pad[w_idx[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_chan  = w_idx[SEL_W-1:0];
      end
    end

    // Fixed mode has a candidate only for an in-range select.
    w_fix_ok = ({1'b0, i_sel} < (SEL_W+1)'(CHANNELS));

    w_cand       = i_mode ? w_rr_chan  : i_sel;
    w_cand_ok    = i_mode ? w_rr_found : w_fix_ok;
    w_cand_valid = w_cand_ok && w_valid_pad[w_cand];

    w_cand_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_cand == SEL_W'(i)) begin
        w_cand_data = i_in_data[i*WIDTH +: WIDTH];
      end
    end

    // Ready follows load, not valid; it is forced low while in reset so no
    // handshake can complete then.
    o_in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      o_in_ready[i] = i_rst_n && w_cand_ok && w_load && (w_cand == SEL_W'(i));
    end

    w_xfer = i_rst_n && w_load && w_cand_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      // Pointer at the top channel so channel 0 wins the first arbitration.
      r_last  <= SEL_W'(CHANNELS - 1);
    end else begin
      if (w_load) begin
        // With no transfer the register empties but keeps its last contents.
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_data <= w_cand_data;
          r_chan <= w_cand;
        end
      end
      // Fixed-mode transfers leave the round-robin history untouched.
      if (w_xfer && i_mode) begin
        r_last <= w_cand;
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_out_chan  = r_chan;

endmodule
